// File: rtl/seq_udiv_p48_b16_if.sv
// Handshake/data bundle for seq_udiv_p48_b16: operand channel (p, b, carryin) and
// result channel (q, r, div_zero), each with its own valid/ready pair.
interface seq_udiv_p48_b16_if #(
   parameter int DW = 48,
   parameter int VW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] p;
   logic [VW-1:0] b;
   logic          carryin;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] q;
   logic [VW-1:0] r;
   logic          div_zero;

   // master = producer of operands / consumer of results; slave = the divider
   modport master (
      output in_valid, p, b, carryin, out_ready,
      input  in_ready, out_valid, q, r, div_zero
   );

   modport slave (
      input  in_valid, p, b, carryin, out_ready,
      output in_ready, out_valid, q, r, div_zero
   );
endinterface

// File: rtl/seq_udiv_p48_b16.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock: q = p / b, r = p % b.
// Optional build macro SEQ_UDIV_CARRYIN_EN divides (p - carryin) to invert p = a*b + carryin.
module seq_udiv_p48_b16 #(
   parameter int DW = 48,
   parameter int VW = 16
) (
   input  logic                clk,
   input  logic                rst,
   seq_udiv_p48_b16_if.slave   bus,
   output logic [1:0]          dbg_state
);
   // Handshake: a transfer happens on a rising edge where valid && ready are both high.
   // A producer holds valid and data until that edge; ready never depends on valid here.

   localparam int CW = $clog2(DW);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_ZERO = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] dvd_q, dvd_d;
   logic [VW:0]   rem_q, rem_d;
   logic [VW-1:0] b_q, b_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] q_q, q_d;
   logic [VW-1:0] r_q, r_d;
   logic          dz_q, dz_d;

   logic [DW-1:0] dividend;
   logic [VW:0]   rem_shift;
   logic [VW:0]   rem_sub;
   logic          rem_ge;

`ifdef SEQ_UDIV_CARRYIN_EN
   assign dividend = bus.p - DW'(bus.carryin);
`else
   logic unused_carryin;
   assign unused_carryin = bus.carryin;
   assign dividend       = bus.p;
`endif

   // A set top bit of the partial remainder already means it exceeds any VW-bit divisor.
   assign rem_shift = {rem_q[VW-1:0], dvd_q[DW-1]};
   assign rem_ge    = rem_q[VW] | (rem_shift >= {1'b0, b_q});
   assign rem_sub   = rem_shift - {1'b0, b_q};

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      rem_d   = rem_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               dvd_d   = dividend;
               b_d     = bus.b;
               rem_d   = '0;
               cnt_d   = CW'(DW - 1);
               state_d = (bus.b == '0) ? S_ZERO : S_CALC;
            end
         end
         S_CALC: begin
            rem_d = rem_ge ? rem_sub : rem_shift;
            dvd_d = {dvd_q[DW-2:0], rem_ge};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               q_d     = {dvd_q[DW-2:0], rem_ge};
               r_d     = rem_d[VW-1:0];
               dz_d    = 1'b0;
               state_d = S_DONE;
            end
         end
         S_ZERO: begin
            // Divide by zero: saturated quotient, the dividend's low bits as remainder.
            q_d     = '1;
            r_d     = dvd_q[VW-1:0];
            dz_d    = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         dvd_q   <= '0;
         rem_q   <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         rem_q   <= rem_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.q         = q_q;
   assign bus.r         = r_q;
   assign bus.div_zero  = dz_q;
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_seq_udiv_p48_b16.sv
// Scoreboard bench for seq_udiv_p48_b16: directed corner cases plus randomized operands
// with random output backpressure, checked against a plain-arithmetic reference model.
module tb_seq_udiv_p48_b16;
   localparam int DW = 48;
   localparam int VW = 16;
   localparam int RW = DW + VW + 1;
`ifdef SEQ_UDIV_CARRYIN_EN
   localparam bit CIN_EN = 1'b1;
`else
   localparam bit CIN_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;

   seq_udiv_p48_b16_if #(.DW(DW), .VW(VW)) bus ();

   seq_udiv_p48_b16 #(.DW(DW), .VW(VW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int            checks = 0;
   int            errors = 0;
   logic [RW-1:0] exp_q[$];
   bit            rand_ready = 1'b0;

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model: {div_zero, q, r} ----------------
   function automatic logic [RW-1:0] model(input logic [DW-1:0] pv, input logic [VW-1:0] bv,
                                           input logic cv);
      logic [DW-1:0] d;
      d = CIN_EN ? (pv - DW'(cv)) : pv;
      if (bv == '0) return {1'b1, {DW{1'b1}}, d[VW-1:0]};
      return {1'b0, d / DW'(bv), VW'(d % DW'(bv))};
   endfunction

   task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [DW-1:0] pv, input logic [VW-1:0] bv, input logic cv);
      int            n;
      logic [63:0]   junk;
      exp_q.push_back(model(pv, bv, cv));
      bus.p        = pv;
      bus.b        = bv;
      bus.carryin  = cv;
      bus.in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.in_ready && n < 500);
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", n);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      junk         = {$urandom, $urandom};
      bus.p        = junk[DW-1:0];
      bus.b        = junk[VW-1:0];
      bus.carryin  = junk[63];
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.out_valid) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout: out_valid 0 after %0d cycles, expected 1", n);
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      end
   endtask

   // ---------------- random output backpressure ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      bit            hold_pend;
      logic [RW-1:0] hold_val;
      logic [RW-1:0] got;
      hold_pend = 1'b0;
      hold_val  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_pend = 1'b0;
         end else begin
            got = {bus.div_zero, bus.q, bus.r};
            if (hold_pend) begin
               chk("hold_valid", RW'(bus.out_valid), RW'(1));
               chk("hold_data", got, hold_val);
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got 0x%0h expected no result", got);
               end else begin
                  chk("result", got, exp_q.pop_front());
               end
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_val  = got;
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int            n;
      logic [63:0]   rnd;
      logic [DW-1:0] pv;
      logic [VW-1:0] bv;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.p         = '0;
      bus.b         = '0;
      bus.carryin   = 1'b0;
      bus.out_ready = 1'b1;

      // Reset values are visible before the first clock edge.
      #2;
      chk("rst_in_ready", RW'(bus.in_ready), RW'(1));
      chk("rst_out_valid", RW'(bus.out_valid), RW'(0));
      chk("rst_q", RW'(bus.q), RW'(0));
      chk("rst_r", RW'(bus.r), RW'(0));
      chk("rst_div_zero", RW'(bus.div_zero), RW'(0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      send(48'd836, 16'd22, 1'b0);
      wait_valid(n);
      chk("lat_normal", RW'(n), RW'(DW));
      drain(50);

      send(48'd837, 16'd22, 1'b1);
      wait_valid(n);
      drain(50);

      send(48'hFFFF_FFFF_FFFF, 16'hFFFF, 1'b0);
      wait_valid(n);
      drain(50);
      send(48'd396, 16'd12, 1'b0);
      wait_valid(n);
      drain(50);

      send(48'd1234, 16'd0, 1'b0);
      wait_valid(n);
      chk("lat_div_zero", RW'(n), RW'(1));
      drain(50);

      // Held result under backpressure; a pending request must not be taken.
      bus.out_ready = 1'b0;
      send(48'd100000, 16'd7, 1'b0);
      wait_valid(n);
      bus.in_valid = 1'b1;
      bus.p        = 48'd5;
      bus.b        = 16'd1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold_in_ready", RW'(bus.in_ready), RW'(0));
      end
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drain(50);
      chk("release_in_ready", RW'(bus.in_ready), RW'(1));

      // Reset in the middle of a calculation discards the op.
      send(48'd999999, 16'd13, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", RW'(bus.out_valid), RW'(0));
      chk("mid_rst_q", RW'(bus.q), RW'(0));
      chk("mid_rst_r", RW'(bus.r), RW'(0));
      chk("mid_rst_div_zero", RW'(bus.div_zero), RW'(0));
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", RW'(bus.in_ready), RW'(1));
      send(48'd396, 16'd12, 1'b0);
      wait_valid(n);
      drain(50);

      // Randomized operands with random output backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         rnd = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0:       pv = '0;
            1:       pv = '1;
            default: pv = rnd[DW-1:0];
         endcase
         case ($urandom_range(0, 9))
            0:       bv = '0;
            1, 2, 3: bv = VW'($urandom_range(1, 255));
            4:       bv = '1;
            default: bv = VW'($urandom);
         endcase
         send(pv, bv, 1'($urandom_range(0, 1)));
      end
      drain(3000);
      rand_ready    = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
